// File: rtl/wrr_bus_scheduler.sv
// Weighted round-robin bus scheduler.
// N masters share one bus. Each owner keeps the bus for a programmable quantum of
// weight+1 cycles. A one-cycle turnaround gap separates one owner from the next.
// All outputs are registered, so there is no combinational path from inputs to outputs.
module wrr_bus_scheduler #(
  parameter int N              = 4,
  parameter int WW             = 4,
  parameter int DEFAULT_WEIGHT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_cfg_we,
  input  logic [2:0]    i_cfg_idx,
  input  logic [WW-1:0] i_cfg_weight,
  output logic [N-1:0]  o_gnt,
  output logic [2:0]    o_gnt_id,
  output logic          o_gnt_valid,
  output logic          o_quantum_exp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [2:0]    r_ptr;
  logic [2:0]    w_ptrNext;
  logic [2:0]    r_owner;
  logic [2:0]    w_ownerNext;
  logic [WW-1:0] r_credit;
  logic [WW-1:0] w_creditNext;
  logic [WW-1:0] r_weight [N];

  logic [2:0]    w_winner;
  logic          w_winnerFound;
  logic [WW-1:0] w_winnerWeight;
  logic [WW-1:0] w_ownerWeight;
  logic          w_ownerReq;
  logic          w_otherReq;
  logic [2:0]    w_ownerInc;

  logic [N-1:0]  r_gnt;
  logic [2:0]    r_gntId;
  logic          r_gntValid;
  logic          r_quantumExp;
  logic [N-1:0]  w_gntNext;
  logic [2:0]    w_gntIdNext;
  logic          w_quantumExpNext;

  // Find the first requester at or after ptr. If there is none, wrap round to the lower indices.
  always_comb begin
    w_winner      = '0;
    w_winnerFound = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_winnerFound && i_req[i] && (3'(i) >= r_ptr)) begin
        w_winner      = 3'(i);
        w_winnerFound = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_winnerFound && i_req[i] && (3'(i) < r_ptr)) begin
        w_winner      = 3'(i);
        w_winnerFound = 1'b1;
      end
    end
  end

  // Look up the winner and the owner. The index loops keep every select within the vector width.
  always_comb begin
    w_winnerWeight = '0;
    w_ownerWeight  = '0;
    w_ownerReq     = 1'b0;
    w_otherReq     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (3'(i) == w_winner) w_winnerWeight = r_weight[i];
      if (3'(i) == r_owner) begin
        w_ownerWeight = r_weight[i];
        w_ownerReq    = i_req[i];
      end else if (i_req[i]) begin
        w_otherReq = 1'b1;
      end
    end
    w_ownerInc = (r_owner == 3'(N - 1)) ? 3'd0 : r_owner + 3'd1;
  end

  // Next-state logic: decide on ownership, spend and reload credit, and advance the pointer.
  always_comb begin
    w_stateNext  = r_state;
    w_ownerNext  = r_owner;
    w_ptrNext    = r_ptr;
    w_creditNext = r_credit;
    case (r_state)
      IDLE: begin
        if (w_winnerFound) begin
          w_stateNext  = OWN;
          w_ownerNext  = w_winner;
          w_creditNext = w_winnerWeight;
        end
      end
      OWN: begin
        if (!w_ownerReq) begin
          w_stateNext = GAP;
          w_ptrNext   = w_ownerInc;
        end else if ((r_credit == '0) && w_otherReq) begin
          w_stateNext = GAP;
          w_ptrNext   = w_ownerInc;
        end else if (r_credit == '0) begin
          w_creditNext = w_ownerWeight;
        end else begin
          w_creditNext = r_credit - 1'b1;
        end
      end
      GAP: begin
        if (w_winnerFound) begin
          w_stateNext  = OWN;
          w_ownerNext  = w_winner;
          w_creditNext = w_winnerWeight;
        end else begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Output logic: work out the value each output register takes for the upcoming state.
  always_comb begin
    w_gntNext   = '0;
    w_gntIdNext = '0;
    if (w_stateNext == OWN) begin
      w_gntIdNext = w_ownerNext;
      for (int i = 0; i < N; i++) begin
        w_gntNext[i] = (3'(i) == w_ownerNext);
      end
    end
    w_quantumExpNext = (r_state == OWN) && w_ownerReq && (r_credit == '0) && w_otherReq;
  end

  // State register, together with the registered outputs. Reset clears the grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_credit     <= '0;
      r_gnt        <= '0;
      r_gntId      <= '0;
      r_gntValid   <= 1'b0;
      r_quantumExp <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_ptr        <= w_ptrNext;
      r_owner      <= w_ownerNext;
      r_credit     <= w_creditNext;
      r_gnt        <= w_gntNext;
      r_gntId      <= w_gntIdNext;
      r_gntValid   <= |w_gntNext;
      r_quantumExp <= w_quantumExpNext;
    end
  end

  // Weight registers. A load in the same cycle as a write sees the old value; out-of-range indices are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_weight[i] <= WW'(DEFAULT_WEIGHT);
    end else if (i_cfg_we) begin
      for (int i = 0; i < N; i++) begin
        if (i_cfg_idx == 3'(i)) r_weight[i] <= i_cfg_weight;
      end
    end
  end

  assign o_gnt         = r_gnt;
  assign o_gnt_id      = r_gntId;
  assign o_gnt_valid   = r_gntValid;
  assign o_quantum_exp = r_quantumExp;

endmodule

// File: tb/tb_wrr_bus_scheduler.sv
// Directed testbench for wrr_bus_scheduler with N=4, WW=4, DEFAULT_WEIGHT=3.
// Inputs are driven 1 time unit after each rising edge. Outputs are checked at that same point.
module tb_wrr_bus_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       cfgWe;
  logic [2:0] cfgIdx;
  logic [3:0] cfgWeight;
  logic [3:0] gnt;
  logic [2:0] gntId;
  logic       gntValid;
  logic       quantumExp;

  int errors = 0;
  int checks = 0;

  wrr_bus_scheduler #(.N(4), .WW(4), .DEFAULT_WEIGHT(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (req),
    .i_cfg_we     (cfgWe),
    .i_cfg_idx    (cfgIdx),
    .i_cfg_weight (cfgWeight),
    .o_gnt        (gnt),
    .o_gnt_id     (gntId),
    .o_gnt_valid  (gntValid),
    .o_quantum_exp(quantumExp)
  );

  // Free-running clock with a 10-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard timer, in case the bench ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus(input logic [3:0] r, input logic we, input logic [2:0] idx,
                               input logic [3:0] w);
    req       = r;
    cfgWe     = we;
    cfgIdx    = idx;
    cfgWeight = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input logic [3:0] expGnt, input logic expQexp, input string tag);
    logic [2:0] expId;
    expId = 3'd0;
    for (int i = 0; i < 4; i++) if (expGnt[i]) expId = 3'(i);
    checks++;
    assert (gnt === expGnt) else begin
      errors++;
      $error("[TB] FAIL %s gnt got=%b exp=%b", tag, gnt, expGnt);
    end
    checks++;
    assert (gntId === expId) else begin
      errors++;
      $error("[TB] FAIL %s gnt_id got=%0d exp=%0d", tag, gntId, expId);
    end
    checks++;
    assert (gntValid === (expGnt != 4'b0)) else begin
      errors++;
      $error("[TB] FAIL %s gnt_valid got=%b exp=%b", tag, gntValid, (expGnt != 4'b0));
    end
    checks++;
    assert (quantumExp === expQexp) else begin
      errors++;
      $error("[TB] FAIL %s quantum_exp got=%b exp=%b", tag, quantumExp, expQexp);
    end
  endtask

  task automatic stepCheck(input logic [3:0] expGnt, input logic expQexp, input string tag,
                           input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      checkOutput(expGnt, expQexp, tag);
    end
  endtask

  // Directed sequence. The expected grants were worked out by hand from the pointer and weights.
  initial begin
    rst_n = 1'b0;
    applyStimulus(4'b0000, 1'b0, 3'd0, 4'd0);
    tick();
    tick();
    checkOutput(4'b0000, 1'b0, "reset");
    rst_n = 1'b1;

    // T1: two masters with default weights. Quanta of 4 cycles, separated by expiring gaps.
    applyStimulus(4'b0011, 1'b0, 3'd0, 4'd0);
    stepCheck(4'b0001, 1'b0, "t1_m0", 4);
    stepCheck(4'b0000, 1'b1, "t1_gap0", 1);
    stepCheck(4'b0010, 1'b0, "t1_m1", 4);
    stepCheck(4'b0000, 1'b1, "t1_gap1", 1);
    stepCheck(4'b0001, 1'b0, "t1_m0b", 1);
    applyStimulus(4'b0000, 1'b0, 3'd0, 4'd0);
    stepCheck(4'b0000, 1'b0, "t1_release", 1);
    stepCheck(4'b0000, 1'b0, "t1_idle", 1);

    // T2: one requester keeps the bus with no gaps, because its credit reloads
    applyStimulus(4'b0100, 1'b0, 3'd0, 4'd0);
    stepCheck(4'b0100, 1'b0, "t2_solo", 10);
    applyStimulus(4'b0000, 1'b0, 3'd0, 4'd0);
    stepCheck(4'b0000, 1'b0, "t2_release", 1);
    stepCheck(4'b0000, 1'b0, "t2_idle", 1);

    // T3: w1=0 and w0=1. The write to index 4 lies outside N and must be ignored.
    applyStimulus(4'b0000, 1'b1, 3'd1, 4'd0);
    stepCheck(4'b0000, 1'b0, "t3_cfg1", 1);
    applyStimulus(4'b0000, 1'b1, 3'd0, 4'd1);
    stepCheck(4'b0000, 1'b0, "t3_cfg0", 1);
    applyStimulus(4'b0000, 1'b1, 3'd4, 4'd0);
    stepCheck(4'b0000, 1'b0, "t3_cfg4", 1);
    applyStimulus(4'b0011, 1'b0, 3'd0, 4'd0);
    stepCheck(4'b0001, 1'b0, "t3_m0", 2);
    stepCheck(4'b0000, 1'b1, "t3_gap0", 1);
    stepCheck(4'b0010, 1'b0, "t3_m1", 1);
    stepCheck(4'b0000, 1'b1, "t3_gap1", 1);
    stepCheck(4'b0001, 1'b0, "t3_m0b", 2);
    stepCheck(4'b0000, 1'b1, "t3_gap2", 1);
    stepCheck(4'b0010, 1'b0, "t3_m1b", 1);
    applyStimulus(4'b0000, 1'b0, 3'd0, 4'd0);
    stepCheck(4'b0000, 1'b0, "t3_release", 1);
    stepCheck(4'b0000, 1'b0, "t3_idle", 1);

    // A weight write in the same cycle as a grant: the grant loads the old w0=1, and later loads use 3
    applyStimulus(4'b0011, 1'b1, 3'd0, 4'd3);
    stepCheck(4'b0001, 1'b0, "old_m0", 1);
    applyStimulus(4'b0011, 1'b0, 3'd0, 4'd0);
    stepCheck(4'b0001, 1'b0, "old_m0", 1);
    stepCheck(4'b0000, 1'b1, "old_gap0", 1);
    stepCheck(4'b0010, 1'b0, "old_m1", 1);
    stepCheck(4'b0000, 1'b1, "old_gap1", 1);
    stepCheck(4'b0001, 1'b0, "new_m0", 4);
    stepCheck(4'b0000, 1'b1, "new_gap", 1);
    applyStimulus(4'b0000, 1'b0, 3'd0, 4'd0);
    stepCheck(4'b0000, 1'b0, "gap_to_idle", 1);

    // T4: reset, then master 0 releases early. There is no pulse, and master 3 gets a full quantum.
    rst_n = 1'b0;
    tick();
    checkOutput(4'b0000, 1'b0, "t4_reset");
    rst_n = 1'b1;
    applyStimulus(4'b1001, 1'b0, 3'd0, 4'd0);
    stepCheck(4'b0001, 1'b0, "t4_m0", 2);
    applyStimulus(4'b1000, 1'b0, 3'd0, 4'd0);
    stepCheck(4'b0000, 1'b0, "t4_release", 1);
    stepCheck(4'b1000, 1'b0, "t4_m3", 4);
    applyStimulus(4'b0000, 1'b0, 3'd0, 4'd0);
    stepCheck(4'b0000, 1'b0, "t4_gap", 1);
    stepCheck(4'b0000, 1'b0, "t4_idle", 1);

    // T5: every weight is 0 and all four request. The grant order is 0,1,2,3 and wraps back to 0.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0000, 1'b1, 3'(i), 4'd0);
      stepCheck(4'b0000, 1'b0, "t5_cfg", 1);
    end
    applyStimulus(4'b1111, 1'b0, 3'd0, 4'd0);
    stepCheck(4'b0001, 1'b0, "t5_m0", 1);
    stepCheck(4'b0000, 1'b1, "t5_gap", 1);
    stepCheck(4'b0010, 1'b0, "t5_m1", 1);
    stepCheck(4'b0000, 1'b1, "t5_gap", 1);
    stepCheck(4'b0100, 1'b0, "t5_m2", 1);
    stepCheck(4'b0000, 1'b1, "t5_gap", 1);
    stepCheck(4'b1000, 1'b0, "t5_m3", 1);
    stepCheck(4'b0000, 1'b1, "t5_gap", 1);
    stepCheck(4'b0001, 1'b0, "t5_wrap", 1);
    applyStimulus(4'b0000, 1'b0, 3'd0, 4'd0);
    stepCheck(4'b0000, 1'b0, "t5_release", 1);
    stepCheck(4'b0000, 1'b0, "t5_idle", 1);

    // T6: asynchronous reset in the middle of master 2's quantum. Afterwards w0 must be back to 3.
    applyStimulus(4'b0000, 1'b1, 3'd2, 4'd3);
    stepCheck(4'b0000, 1'b0, "t6_cfg", 1);
    applyStimulus(4'b0100, 1'b0, 3'd0, 4'd0);
    stepCheck(4'b0100, 1'b0, "t6_m2", 2);
    rst_n = 1'b0;
    #1;
    checkOutput(4'b0000, 1'b0, "t6_async");
    tick();
    checkOutput(4'b0000, 1'b0, "t6_hold");
    rst_n = 1'b1;
    stepCheck(4'b0100, 1'b0, "t6_regrant", 1);
    applyStimulus(4'b0101, 1'b0, 3'd0, 4'd0);
    stepCheck(4'b0100, 1'b0, "t6_m2q", 3);
    stepCheck(4'b0000, 1'b1, "t6_gap", 1);
    stepCheck(4'b0001, 1'b0, "t6_m0w3", 4);
    stepCheck(4'b0000, 1'b1, "t6_gap2", 1);
    applyStimulus(4'b0000, 1'b0, 3'd0, 4'd0);
    stepCheck(4'b0000, 1'b0, "t6_idle", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
